// File: rtl/sparse_cnn_pkg.sv
// Shared types and helpers for the sparse CNN partial-sum datapath.
package sparse_cnn_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned COORD_W_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Clamp a sign-extended value into the signed range of a w-bit word (w <= 64).
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      res = hi;
    else if (v < lo) res = lo;
    else             res = v;
    return res;
  endfunction

endpackage

// File: rtl/sparse_psum_accumulator_psum_buffer.sv
// OUT_SIZE x OUT_SIZE accumulator array with a saturating accumulate port and a drain read/clear port.
module psum_buffer
  import sparse_cnn_pkg::*;
#(
  parameter int unsigned OUT_SIZE = 24,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned COORD_W  = COORD_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_en,
  input  logic [COORD_W-1:0]        acc_row,
  input  logic [COORD_W-1:0]        acc_col,
  input  logic signed [DATA_W-1:0]  acc_addend,
  input  logic [COORD_W-1:0]        rd_row,
  input  logic [COORD_W-1:0]        rd_col,
  input  logic                      clr_en,
  output logic signed [ACC_W-1:0]   rd_data
);

  localparam int unsigned DEPTH  = OUT_SIZE * OUT_SIZE;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic signed [ACC_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]       acc_addr;
  logic [ADDR_W-1:0]       rd_addr;
  logic signed [ACC_W:0]   sum;
  logic signed [63:0]      sum_sat;
  logic signed [ACC_W-1:0] acc_next;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [COORD_W-1:0] r,
                                                 input logic [COORD_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(OUT_SIZE) + ADDR_W'(c);
  endfunction

  assign acc_addr = lin_addr(acc_row, acc_col);
  assign rd_addr  = lin_addr(rd_row, rd_col);
  assign rd_data  = mem[rd_addr];

  // One guard bit is enough to detect overflow of a single ACC_W + DATA_W addition.
  always_comb begin
    sum      = $signed({mem[acc_addr][ACC_W-1], mem[acc_addr]}) + (ACC_W+1)'(acc_addend);
    sum_sat  = sat_to_width(64'(sum), ACC_W);
    acc_next = sum_sat[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (acc_en) mem[acc_addr] <= acc_next;
      if (clr_en) mem[rd_addr]  <= '0;
    end
  end

endmodule

// File: rtl/sparse_psum_accumulator.sv
// Accumulates sparse partial products over NUM_IN_CH passes, then drains the map in raster order.
module sparse_psum_accumulator
  import sparse_cnn_pkg::*;
#(
  parameter int unsigned OUT_SIZE  = 24,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned COORD_W   = COORD_W_DEF,
  parameter int unsigned NUM_IN_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic signed [DATA_W-1:0] psum_data,
  input  logic [COORD_W-1:0]       psum_row,
  input  logic [COORD_W-1:0]       psum_col,
  input  logic                     psum_last,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [COORD_W-1:0]       out_row,
  output logic [COORD_W-1:0]       out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     oob_err
);

  localparam int unsigned      CH_W = $clog2(NUM_IN_CH + 1);
  localparam logic [COORD_W-1:0] LAST_IDX = COORD_W'(OUT_SIZE - 1);

  state_t                  state;
  logic [CH_W-1:0]         ch_cnt;
  logic                    relu_q;
  logic                    xfer;
  logic                    in_range;
  logic                    clr_en;
  logic [COORD_W-1:0]      nxt_row;
  logic [COORD_W-1:0]      nxt_col;
  logic signed [ACC_W-1:0] rd_data;
  logic signed [ACC_W-1:0] v_relu;
  logic signed [63:0]      v_sat;

  assign xfer     = psum_valid & psum_ready;
  assign in_range = (psum_row < COORD_W'(OUT_SIZE)) && (psum_col < COORD_W'(OUT_SIZE));
  assign clr_en   = (state == DRAIN) & out_valid & out_ready;

  psum_buffer #(
    .OUT_SIZE (OUT_SIZE),
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .COORD_W  (COORD_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .acc_en     (xfer & in_range),
    .acc_row    (psum_row),
    .acc_col    (psum_col),
    .acc_addend (psum_data),
    .rd_row     (out_row),
    .rd_col     (out_col),
    .clr_en     (clr_en),
    .rd_data    (rd_data)
  );

  always_comb begin
    nxt_row = out_row;
    nxt_col = out_col + COORD_W'(1);
    if (out_col == LAST_IDX) begin
      nxt_col = '0;
      nxt_row = out_row + COORD_W'(1);
    end
  end

  // Pixel data is read straight from the buffer at the registered drain pointer; the
  // pointer only moves on a handshake, so the value holds during back-pressure.
  always_comb begin
    v_relu   = (relu_q && (rd_data < 0)) ? '0 : rd_data;
    v_sat    = sat_to_width(64'(v_relu), DATA_W);
    out_data = out_valid ? v_sat[DATA_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      ch_cnt     <= '0;
      relu_q     <= 1'b0;
      psum_ready <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      busy       <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (xfer) begin
            busy <= 1'b1;
            if (!in_range) oob_err <= 1'b1;
            if (psum_last) begin
              if (ch_cnt == CH_W'(NUM_IN_CH - 1)) begin
                ch_cnt     <= '0;
                relu_q     <= relu_en;
                state      <= DRAIN;
                psum_ready <= 1'b0;
                out_valid  <= 1'b1;
                out_row    <= '0;
                out_col    <= '0;
                out_last   <= (OUT_SIZE == 1);
              end else begin
                ch_cnt <= ch_cnt + CH_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state      <= ACCUM;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_row    <= '0;
              out_col    <= '0;
              psum_ready <= 1'b1;
              busy       <= 1'b0;
            end else begin
              out_row  <= nxt_row;
              out_col  <= nxt_col;
              out_last <= (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_psum_accumulator.sv
// Self-checking bench: directed corner sequences, a saturation/ReLU table and random frames vs. an array model.
module tb_sparse_psum_accumulator;

  localparam int unsigned OS  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 24;
  localparam int unsigned CW  = 8;
  localparam int unsigned NCH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 psum_valid = 1'b0;
  logic                 psum_ready;
  logic signed [DW-1:0] psum_data = '0;
  logic [CW-1:0]        psum_row = '0;
  logic [CW-1:0]        psum_col = '0;
  logic                 psum_last = 1'b0;
  logic                 relu_en = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic [CW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic                 out_last;
  logic                 busy;
  logic                 oob_err;

  sparse_psum_accumulator #(
    .OUT_SIZE  (OS),
    .DATA_W    (DW),
    .ACC_W     (AW),
    .COORD_W   (CW),
    .NUM_IN_CH (NCH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .psum_row   (psum_row),
    .psum_col   (psum_col),
    .psum_last  (psum_last),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .oob_err    (oob_err)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint mdl [OS][OS];
  int     mdl_ch = 0;
  bit     mdl_relu = 1'b0;
  bit     mdl_oob = 1'b0;
  bit     mdl_drain = 1'b0;
  longint got_px [OS*OS];

  typedef struct {
    bit     relu;
    longint val;
    int     cnt;
    longint exp00;
  } sat_vec_t;

  function automatic longint clamp(longint v, int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < OS; r++)
      for (int c = 0; c < OS; c++) mdl[r][c] = 0;
    mdl_ch = 0; mdl_relu = 1'b0; mdl_oob = 1'b0; mdl_drain = 1'b0;
  endtask

  task automatic send_psum(longint d, int r, int c, bit l);
    check("psum_ready_accum", longint'(psum_ready), 1);
    psum_valid = 1'b1;
    psum_data  = DW'(d);
    psum_row   = CW'(r);
    psum_col   = CW'(c);
    psum_last  = l;
    @(posedge clk); #1;
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    if (r < OS && c < OS) mdl[r][c] = clamp(mdl[r][c] + d, AW);
    else mdl_oob = 1'b1;
    if (l) begin
      mdl_ch++;
      if (mdl_ch == NCH) begin
        mdl_ch = 0; mdl_relu = relu_en; mdl_drain = 1'b1;
      end
    end
    check("oob_err", longint'(oob_err), longint'(mdl_oob));
    check("busy_after_accept", longint'(busy), 1);
    if (mdl_drain) begin
      check("out_valid_latency", longint'(out_valid), 1);
      check("psum_ready_drain", longint'(psum_ready), 0);
    end else begin
      check("no_early_drain", longint'(out_valid), 0);
    end
  endtask

  task automatic idle_last();
    psum_valid = 1'b0;
    psum_last  = 1'b1;
    @(posedge clk); #1;
    psum_last = 1'b0;
    check("idle_last_ignored", longint'(out_valid), 0);
  endtask

  task automatic finish_frame();
    while (!mdl_drain) send_psum(0, OS - 1, OS - 1, 1'b1);
  endtask

  task automatic drain_check(int stall_idx, int stall_n, int rst_idx);
    bit     stop;
    int     r, c;
    longint v, e;
    stop = 1'b0;
    for (int idx = 0; idx < OS * OS && !stop; idx++) begin
      r = idx / OS;
      c = idx % OS;
      v = mdl[r][c];
      if (mdl_relu && v < 0) v = 0;
      e = clamp(v, DW);
      check("drain_valid", longint'(out_valid), 1);
      check("drain_row", longint'(out_row), r);
      check("drain_col", longint'(out_col), c);
      check("drain_data", longint'($signed(out_data)), e);
      check("drain_last", longint'(out_last), (idx == OS * OS - 1) ? 1 : 0);
      got_px[idx] = longint'($signed(out_data));
      if (idx == rst_idx) begin
        rst = 1'b1;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_psum_ready", longint'(psum_ready), 1);
        check("rst_busy", longint'(busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        stop = 1'b1;
      end else begin
        if (idx == stall_idx) begin
          out_ready = 1'b0;
          repeat (stall_n) begin
            @(posedge clk); #1;
            check("stall_valid", longint'(out_valid), 1);
            check("stall_row", longint'(out_row), r);
            check("stall_col", longint'(out_col), c);
            check("stall_data", longint'($signed(out_data)), e);
            check("stall_psum_ready", longint'(psum_ready), 0);
          end
          out_ready = 1'b1;
        end
        @(posedge clk); #1;
        mdl[r][c] = 0;
      end
    end
    if (!stop) begin
      mdl_drain = 1'b0;
      check("post_drain_valid", longint'(out_valid), 0);
      check("post_drain_ready", longint'(psum_ready), 1);
      check("post_drain_busy", longint'(busy), 0);
    end
  endtask

  function automatic int rand_coord();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(OS, 255));
    return int'($urandom_range(0, OS - 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    sat_vec_t vecs [5];
    vecs[0] = '{relu: 1'b0, val:  30000, cnt: 3, exp00:  32767};
    vecs[1] = '{relu: 1'b1, val: -30000, cnt: 2, exp00:      0};
    vecs[2] = '{relu: 1'b0, val: -30000, cnt: 2, exp00: -32768};
    vecs[3] = '{relu: 1'b1, val:   1234, cnt: 2, exp00:   2468};
    vecs[4] = '{relu: 1'b0, val:   -100, cnt: 3, exp00:   -300};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_psum_ready", longint'(psum_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_last", longint'(out_last), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_oob_err", longint'(oob_err), 0);
    check("reset_out_data", longint'($signed(out_data)), 0);
    check("reset_out_row", longint'(out_row), 0);
    check("reset_out_col", longint'(out_col), 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back accumulation to one address, idle cycles with psum_last must not count.
    send_psum(5, 0, 0, 1'b0);
    send_psum(7, 0, 0, 1'b0);
    send_psum(-2, 3, 3, 1'b1);
    idle_last();
    idle_last();
    finish_frame();
    drain_check(-1, 0, -1);
    check("b2b_pixel_00", got_px[0], 12);
    check("b2b_pixel_33", got_px[15], -2);

    // One psum per pass; drain only after the last channel.
    check("busy_idle", longint'(busy), 0);
    for (int p = 0; p < NCH; p++) send_psum(100, 1, 2, 1'b1);
    drain_check(-1, 0, -1);
    check("multi_pass_12", got_px[6], 400);

    foreach (vecs[i]) begin
      relu_en = vecs[i].relu;
      for (int k = 0; k < vecs[i].cnt; k++) send_psum(vecs[i].val, 0, 0, k == vecs[i].cnt - 1);
      finish_frame();
      relu_en = ~relu_en;
      drain_check(-1, 0, -1);
      check("sat_table_00", got_px[0], vecs[i].exp00);
    end

    // Accumulator clamps at +2^23-1 rather than wrapping, so the later negatives land at -1.
    relu_en = 1'b0;
    for (int k = 0; k < 257; k++) send_psum(32767, 1, 1, 1'b0);
    for (int k = 0; k < 256; k++) send_psum(-32768, 1, 1, k == 255);
    finish_frame();
    drain_check(-1, 0, -1);
    check("acc_sat_11", got_px[5], -1);

    check("oob_before", longint'(oob_err), 0);
    send_psum(123, 4, 0, 1'b1);
    finish_frame();
    drain_check(-1, 0, -1);
    check("oob_sticky", longint'(oob_err), 1);

    send_psum(321, 0, 2, 1'b1);
    send_psum(-9, 2, 1, 1'b0);
    finish_frame();
    drain_check(2, 5, -1);
    check("stall_pixel_02", got_px[2], 321);
    send_psum(11, 3, 0, 1'b1);
    finish_frame();
    drain_check(-1, 0, -1);
    check("second_frame_02", got_px[2], 0);

    send_psum(55, 2, 1, 1'b1);
    finish_frame();
    drain_check(-1, 0, 9);
    check("rst_clears_oob", longint'(oob_err), 0);
    send_psum(-77, 1, 3, 1'b1);
    finish_frame();
    drain_check(-1, 0, -1);
    check("post_rst_13", got_px[7], -77);
    check("post_rst_21", got_px[9], 0);

    for (int f = 0; f < 6; f++) begin
      relu_en = 1'($urandom_range(0, 1));
      while (!mdl_drain) begin
        int n;
        n = int'($urandom_range(0, 5));
        for (int k = 0; k < n; k++) begin
          send_psum(longint'($urandom_range(0, 65535)) - 32768, rand_coord(), rand_coord(), 1'b0);
          if ($urandom_range(0, 7) == 0) idle_last();
        end
        send_psum(longint'($urandom_range(0, 65535)) - 32768, rand_coord(), rand_coord(), 1'b1);
      end
      relu_en = 1'($urandom_range(0, 1));
      drain_check((f == 2) ? int'($urandom_range(0, OS * OS - 1)) : -1, 3, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
